// File: rtl/add_tree_arbiter_if.sv
// Requester, add-tree and response signals shared between clients and add_tree_arbiter.
interface add_tree_arbiter_if #(
  parameter int WIDTH   = 16,
  parameter int NUM_REQ = 4
);
  logic                                  en;
  logic [NUM_REQ-1:0]                    req_valid;
  logic [NUM_REQ-1:0][7:0][WIDTH-1:0]    req_data;
  logic [NUM_REQ-1:0]                    req_ready;
  logic                                  tree_valid;
  logic [7:0][WIDTH-1:0]                 tree_inputs;
  logic [WIDTH-1:0]                      tree_result;
  logic [NUM_REQ-1:0]                    rsp_valid;
  logic [WIDTH-1:0]                      rsp_data;
  logic                                  busy;
  logic [31:0]                           grant_count;

  modport slave (
    input  en, req_valid, req_data, tree_result,
    output req_ready, tree_valid, tree_inputs, rsp_valid, rsp_data, busy, grant_count
  );

  modport master (
    output en, req_valid, req_data, tree_result,
    input  req_ready, tree_valid, tree_inputs, rsp_valid, rsp_data, busy, grant_count
  );
endinterface

// File: rtl/add_tree_arbiter.sv
// Round-robin arbiter feeding a shared fixed-latency 8-input add tree; an owner
// tag pipeline steers each returned sum back to its requester.
module add_tree_arbiter #(
  parameter int WIDTH   = 16,
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 3
) (
  input  logic clk,
  input  logic rst,
  add_tree_arbiter_if.slave bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IW-1:0]                ptr;
  logic [IW-1:0]                win;
  logic                         any;
  logic [NUM_REQ-1:0]           ready;
  logic [LATENCY:0]             vld_pipe;
  logic [LATENCY:0][IW-1:0]     own_pipe;
  logic                         tree_valid_q;
  logic [7:0][WIDTH-1:0]        tree_inputs_q;
  logic [NUM_REQ-1:0]           rsp_valid_q;
  logic [WIDTH-1:0]             rsp_data_q;
  logic [31:0]                  grant_count_q;

  // Search starts at ptr and wraps; the first valid requester wins.
  always_comb begin
    logic [IW:0] idx;
    win = '0;
    any = 1'b0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr} + (IW+1)'(k);
      if (idx >= (IW+1)'(NUM_REQ)) idx = idx - (IW+1)'(NUM_REQ);
      if (!any && bus.en && !rst && bus.req_valid[idx[IW-1:0]]) begin
        any = 1'b1;
        win = idx[IW-1:0];
      end
    end
  end

  always_comb begin
    ready = '0;
    if (any) ready[win] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr           <= '0;
      tree_valid_q  <= 1'b0;
      tree_inputs_q <= '0;
      vld_pipe      <= '0;
      own_pipe      <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      grant_count_q <= '0;
    end else begin
      tree_valid_q <= any;
      if (any) begin
        tree_inputs_q <= bus.req_data[win];
        ptr           <= (win == IW'(NUM_REQ-1)) ? '0 : win + 1'b1;
        grant_count_q <= grant_count_q + 32'd1;
      end
      // Stage LATENCY lines up with tree_result for the beat it tags.
      vld_pipe <= {vld_pipe[LATENCY-1:0], any};
      own_pipe <= {own_pipe[LATENCY-1:0], win};
      rsp_valid_q <= '0;
      if (vld_pipe[LATENCY]) begin
        rsp_valid_q[own_pipe[LATENCY]] <= 1'b1;
        rsp_data_q                     <= bus.tree_result;
      end
    end
  end

  assign bus.req_ready   = ready;
  assign bus.tree_valid  = tree_valid_q;
  assign bus.tree_inputs = tree_inputs_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.busy        = (|vld_pipe) | (|rsp_valid_q);
  assign bus.grant_count = grant_count_q;
endmodule

// File: tb/tb_add_tree_arbiter.sv
// Directed and random checks of add_tree_arbiter against a queue-based reference model.
module tb_add_tree_arbiter;
  localparam int W   = 16;
  localparam int N   = 4;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  add_tree_arbiter_if #(.WIDTH(W), .NUM_REQ(N)) bus ();
  add_tree_arbiter #(.WIDTH(W), .NUM_REQ(N), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Behavioural add tree: sum of the operands, delayed LAT cycles, never reset.
  logic [LAT-1:0][W-1:0] tpipe = '0;
  function automatic logic [W-1:0] sum8(input logic [7:0][W-1:0] v);
    int s;
    s = 0;
    for (int j = 0; j < 8; j++) s += int'(v[j]);
    return s[W-1:0];
  endfunction
  always @(posedge clk) begin
    tpipe[0] <= sum8(bus.tree_inputs);
    for (int j = 1; j < LAT; j++) tpipe[j] <= tpipe[j-1];
  end
  assign bus.tree_result = tpipe[LAT-1];

  typedef struct {
    int          due;
    int          own;
    logic [W-1:0] sum;
  } rsp_t;

  rsp_t                   q[$];
  int                     cyc, mptr, last_w;
  logic [31:0]            mcount;
  logic                   exp_tv;
  logic [7:0][W-1:0]      exp_tin;
  int                     nvec = 0;
  int                     nerr = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (mptr + k) % N;
      if (bus.en && bus.req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic rand_data(input int i);
    for (int j = 0; j < 8; j++) bus.req_data[i][j] = W'($urandom);
  endtask

  // One clock: check everything against the model, advance model, cross the edge.
  task automatic cycle();
    int w;
    logic [N-1:0] exp_rdy, exp_rv;
    logic exp_busy;
    #1;
    w = pick();
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    chk("req_ready", 128'(bus.req_ready), 128'(exp_rdy));
    chk("tree_valid", 128'(bus.tree_valid), 128'(exp_tv));
    chk("tree_inputs", 128'(bus.tree_inputs), 128'(exp_tin));
    chk("grant_count", 128'(bus.grant_count), 128'(mcount));
    exp_rv = '0;
    exp_busy = 1'b0;
    foreach (q[k]) if (cyc >= q[k].due - LAT - 1) exp_busy = 1'b1;
    chk("busy", 128'(bus.busy), 128'(exp_busy));
    if (q.size() > 0 && q[0].due == cyc) begin
      exp_rv[q[0].own] = 1'b1;
      chk("rsp_data", 128'(bus.rsp_data), 128'(q[0].sum));
      void'(q.pop_front());
    end
    chk("rsp_valid", 128'(bus.rsp_valid), 128'(exp_rv));
    exp_tv = (w >= 0);
    if (w >= 0) begin
      q.push_back('{due: cyc + LAT + 2, own: w, sum: sum8(bus.req_data[w])});
      exp_tin = bus.req_data[w];
      mcount++;
      mptr = (w + 1) % N;
    end
    last_w = w;
    @(posedge clk);
    #1;
    cyc++;
    if (last_w >= 0) rand_data(last_w);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_grant_count", 128'(bus.grant_count), 128'(0));
    chk("rst_busy", 128'(bus.busy), 128'(0));
    chk("rst_rsp_valid", 128'(bus.rsp_valid), 128'(0));
    chk("rst_tree_valid", 128'(bus.tree_valid), 128'(0));
    chk("rst_req_ready", 128'(bus.req_ready), 128'(0));
    q.delete();
    mptr = 0;
    mcount = '0;
    exp_tv = 1'b0;
    exp_tin = '0;
    bus.req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    bus.req_valid = '0;
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    rst = 1'b1;
    bus.en = 1'b1;
    bus.req_valid = '1;
    for (int i = 0; i < N; i++) rand_data(i);
    cyc = 0; mptr = 0; mcount = '0; exp_tv = 1'b0; exp_tin = '0; last_w = -1;
    #3;
    chk("init_req_ready", 128'(bus.req_ready), 128'(0));
    chk("init_tree_inputs", 128'(bus.tree_inputs), 128'(0));
    chk("init_rsp_data", 128'(bus.rsp_data), 128'(0));
    chk("init_busy", 128'(bus.busy), 128'(0));
    chk("init_grant_count", 128'(bus.grant_count), 128'(0));
    bus.req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single request from requester 2, operands 1..8 -> 36
    for (int j = 0; j < 8; j++) bus.req_data[2][j] = W'(j + 1);
    bus.req_valid = 4'b0100;
    cycle();
    idle(7);
    chk("single_count", 128'(bus.grant_count), 128'(1));

    // All requesters continuously from reset
    do_reset();
    bus.req_valid = '1;
    for (int k = 0; k < 12; k++) cycle();
    idle(7);

    // Overflow: eight 16'hFFFF -> 16'hFFF8
    for (int j = 0; j < 8; j++) bus.req_data[0][j] = 16'hFFFF;
    bus.req_valid = 4'b0001;
    cycle();
    bus.req_valid = '0;
    for (int k = 0; k < 5; k++) cycle();
    chk("overflow_sum", 128'(bus.rsp_data), 128'(16'hFFF8));
    idle(2);

    // en low blocks grants, raising it grants requester ptr
    do_reset();
    bus.en = 1'b0;
    bus.req_valid = '1;
    for (int k = 0; k < 4; k++) cycle();
    bus.en = 1'b1;
    for (int k = 0; k < 3; k++) cycle();
    bus.en = 1'b0;
    for (int k = 0; k < 3; k++) cycle();
    bus.en = 1'b1;
    idle(7);

    // Reset mid-operation discards in-flight beats
    do_reset();
    bus.req_valid = '1;
    for (int k = 0; k < 3; k++) cycle();
    do_reset();
    idle(8);

    // ptr wrap: grant 2 sets ptr=3, lone requester 1 still wins, then ptr=2
    bus.req_valid = 4'b0100;
    cycle();
    bus.req_valid = 4'b0010;
    cycle();
    bus.req_valid = '1;
    for (int k = 0; k < 4; k++) cycle();
    idle(7);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      bus.en = ($urandom_range(0, 7) != 0);
      bus.req_valid = N'($urandom);
      cycle();
    end
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/add_tree_arbiter.md
# add_tree_arbiter

Round-robin arbiter and tag tracker that shares one fixed-latency pipelined 8-input adder tree among NUM_REQ requesters. Each accepted request drives one beat of 8 operands into the tree. The block tracks which requester owns each in-flight beat and routes the returned sum back to that requester as a one-cycle response pulse. It sits between the requester clients and the shared add-tree datapath, and owns all sequencing of that datapath.

## Interface
- WIDTH, 16, data width of each operand and of the sum
- NUM_REQ, 4, number of requesters (2..16)
- LATENCY, 3, cycles from tree_valid/tree_inputs to matching tree_result (fixed, ≥1, no stall)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  grant enable; 0 blocks new grants, in-flight beats still complete
- req_valid  in  NUM_REQ  per-requester request valid
- req_data  in  NUM_REQ×8×WIDTH  per-requester operand sets
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- tree_valid  out  1  beat valid to the tree
- tree_inputs  out  8×WIDTH  operands to the tree
- tree_result  in  WIDTH  tree sum, valid LATENCY cycles after tree_valid
- rsp_valid  out  NUM_REQ  one-hot response pulse to the owning requester
- rsp_data  out  WIDTH  sum for the pulsed requester
- busy  out  1  any beat in flight or any response pending
- grant_count  out  32  total accepted requests since reset, wraps at 2^32

## Operation
- Grant:
  - At most one grant per cycle.
  - Candidates are requesters with req_valid=1, and only when en=1.
  - Priority starts at ptr and wraps: ptr, ptr+1, …, NUM_REQ-1, 0, …
  - req_ready[i]=1 combinationally iff i is the winner. Acceptance = req_valid[i]&req_ready[i].
- Pointer:
  - Reset value 0.
  - After a grant to i, ptr ← (i+1) mod NUM_REQ.
  - With no grant, ptr holds.
- Issue:
  - Acceptance in cycle t registers tree_valid=1 and tree_inputs=req_data[i] for cycle t+1.
  - With no acceptance, tree_valid=0 and tree_inputs hold their last value.
- Tag pipeline:
  - A shift register of depth LATENCY+1 carries {valid, owner index}, aligned so the tag matches tree_result in cycle t+1+LATENCY.
- Response:
  - In cycle t+2+LATENCY: rsp_valid[i]=1 for exactly one cycle, rsp_data = registered tree_result.
  - rsp_valid is otherwise all-zero and rsp_data holds.
  - There is no response backpressure; requesters must sink pulses.
- Arithmetic:
  - The block does no arithmetic on data.
  - Sums are modulo 2^WIDTH as produced by the tree and are passed unmodified.
- busy = OR of the tag-pipeline valids and response valid.
- grant_count increments on each acceptance.

## Timing
- Reset values:
  - req_ready=0, tree_valid=0, tree_inputs=0, rsp_valid=0, rsp_data=0.
  - busy=0, grant_count=0, ptr=0, all tags invalid.
- Request-to-response latency is LATENCY+2 cycles (5 at default).
- Throughput is one beat per cycle aggregate. A lone requester holding req_valid=1 is granted every cycle.
- A requester may change req_data only after acceptance. Dropping req_valid before acceptance is legal and withdraws the request.
- en deasserted mid-stream: no new grants from that cycle. In-flight beats still produce responses. ptr holds.
- Simultaneous events: a grant and a response to the same requester in the same cycle are independent and both occur.
- All NUM_REQ requesting: grants rotate strictly, so each requester waits at most NUM_REQ-1 cycles.
- rst mid-operation:
  - All in-flight tags are discarded; their late tree_result values produce no response.
  - Outputs return to reset values asynchronously.
- ptr wrap: a grant to NUM_REQ-1 sets ptr=0.

## Test plan
- Single request: req_valid[2]=1 with operands 1..8 at cycle 0 → req_ready[2]=1 at cycle 0. tree_valid at cycle 1. rsp_valid=4'b0100, rsp_data=36 at cycle 5. busy cycles 1–5. grant_count=1.
- All four requesters valid continuously from reset → grants in order 0,1,2,3,0,… one per cycle. Responses in the same order, each 5 cycles after its grant.
- Overflow: operands all 16'hFFFF → rsp_data=16'hFFF8.
- en=0 with req_valid=4'b1111 → req_ready=0 throughout. Raising en → first grant to requester ptr (0 after reset).
- rst asserted at cycle 3 after grants at cycles 0–2 → no rsp_valid ever for those grants. grant_count=0, busy=0 immediately.
- Requester 1 valid alone while ptr=3 → granted (wrap search), ptr becomes 2.
